// File: rtl/riscv_pkg.sv
// Shared RV32 core types and constants.
// Fetch-to-decode bundle and reset vector.
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int ILEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } instr_pc_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush.
// Used for prefetch data and in-flight pc tags.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_q];

  // A full FIFO still takes a push when the head leaves this cycle.
  assign do_push = push_i & (~full_o | pop_i);
  assign do_pop  = pop_i & ~empty_o;

  // Pointer and occupancy update; flush empties like reset.
  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage write; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RV32 fetch front end: PC, credit-based
// imem requests, prefetch FIFO, redirects.
module instr_fetch_unit
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = RESET_VECTOR,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [ILEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   drop_q, drop_d;

  logic [CW-1:0]   d_cnt, t_cnt;
  logic            d_full, d_empty;
  logic            t_full, t_empty;
  logic [CW:0]     used;
  logic            xfer;
  logic            keep;
  logic            d_push, d_pop;
  logic [XLEN-1:0] tag_pc;
  instr_pc_t       d_in, d_head;
  logic            unused_bits;

  assign unused_bits = ^{redirect_pc[1:0], t_empty};

  // Buffered plus in-flight words bound the credit.
  assign used = {1'b0, d_cnt} + {1'b0, t_cnt};

  assign imem_req  = ~reset & ~d_full & ~t_full
                   & (used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr = pc_q;
  assign xfer      = imem_req & imem_gnt;

  assign keep   = imem_rvalid & (drop_q == '0);
  assign d_push = keep & ~redirect_valid;
  assign d_pop  = instr_valid & instr_ready
                & ~redirect_valid;

  assign d_in.instr = imem_rdata;
  assign d_in.pc    = tag_pc;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN)
  ) u_tag_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (1'b0),
    .push_i  (xfer),
    .data_i  (pc_q),
    .pop_i   (imem_rvalid),
    .data_o  (tag_pc),
    .count_o (t_cnt),
    .full_o  (t_full),
    .empty_o (t_empty)
  );

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(instr_pc_t))
  ) u_data_q (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect_valid),
    .push_i  (d_push),
    .data_i  (d_in),
    .pop_i   (d_pop),
    .data_o  (d_head),
    .count_o (d_cnt),
    .full_o  (d_full),
    .empty_o (d_empty)
  );

  assign instr_valid = ~reset & ~d_empty;
  assign instr       = instr_valid ? d_head.instr : '0;
  assign instr_pc    = instr_valid ? d_head.pc : '0;

  // Next PC and drop count; a redirect overrides everything.
  always_comb begin
    pc_d   = pc_q;
    drop_d = drop_q;
    if (redirect_valid) begin
      pc_d   = {redirect_pc[XLEN-1:2], 2'b00};
      drop_d = t_cnt + CW'(xfer) - CW'(imem_rvalid);
    end else begin
      if (xfer) pc_d = pc_q + 32'd4;
      if (imem_rvalid && drop_q != '0)
        drop_d = drop_q - 1'b1;
    end
  end

  // PC and drop counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC;
      drop_q <= '0;
    end else begin
      pc_q   <= pc_d;
      drop_q <= drop_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit:
// directed scenarios then random traffic.
module tb_instr_fetch_unit;
  import riscv_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (RPC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          ep;
    int          due;
  } rsp_t;

  rsp_t        memq[$];
  instr_pc_t   buf_m[$];
  instr_pc_t   got[$];
  logic [31:0] mpc;
  int          epoch;
  int          last_due;
  int          cyc;
  int          ngrant;
  int          first_v;
  int          total;
  int          bad;

  function automatic logic [31:0] word_of(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  // One cycle: drive, check against model, advance model.
  // rdauto=1 redirects when a pop and a response coincide.
  task automatic step(bit rst, bit gnt, bit rdy, bit rd,
                      logic [31:0] rpc, int lat,
                      bit rdauto = 1'b0);
    bit   rv, ereq, eval, xfer, pop, rdx;
    int   due;
    rsp_t h;
    rv   = !rst && memq.size() > 0 && memq[0].due <= cyc;
    ereq = (buf_m.size() + memq.size()) < DEPTH;
    eval = buf_m.size() > 0;
    rdx  = rdauto ? (eval && rdy && rv) : rd;
    reset          = rst;
    imem_gnt       = gnt;
    instr_ready    = rdy;
    redirect_valid = rdx && !rst;
    redirect_pc    = rpc;
    imem_rvalid    = rv;
    imem_rdata     = rv ? word_of(memq[0].addr) : $urandom;
    #1;
    if (rst) begin
      chk("rst_req", imem_req, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_instr", instr, 0);
      chk("rst_pc", instr_pc, 0);
      memq.delete();
      buf_m.delete();
      mpc      = RPC;
      epoch++;
      last_due = 0;
    end else begin
      chk("req", imem_req, ereq);
      if (ereq) chk("addr", imem_addr, mpc);
      chk("valid", instr_valid, eval);
      if (eval) begin
        chk("ipc", instr_pc, buf_m[0].pc);
        chk("instr", instr, buf_m[0].instr);
        if (first_v < 0) first_v = cyc;
      end
      xfer = ereq && gnt;
      pop  = eval && rdy && !rdx;
      if (pop) got.push_back(buf_m.pop_front());
      if (rv) begin
        h = memq.pop_front();
        if (!rdx && h.ep == epoch)
          buf_m.push_back('{instr: word_of(h.addr),
                            pc: h.addr});
      end
      if (xfer) begin
        due = cyc + 1 + lat;
        if (due <= last_due) due = last_due + 1;
        memq.push_back('{addr: mpc, ep: epoch, due: due});
        last_due = due;
        mpc      = mpc + 32'd4;
        ngrant++;
      end
      if (rdx) begin
        buf_m.delete();
        epoch++;
        mpc = {rpc[31:2], 2'b00};
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [31:0] a0;
    int          rel;
    total = 0; bad = 0; cyc = 0; epoch = 0;
    last_due = 0; ngrant = 0; first_v = -1;
    mpc = RPC;
    reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; redirect_valid = 1'b0;
    redirect_pc = '0; instr_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset, then streaming with 1-cycle memory.
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    rel = cyc;
    first_v = -1;
    got.delete();
    for (int i = 0; i < 8; i++) step(0, 1, 1, 0, 0, 0);
    chk("t1_first_lat", first_v - rel, 2);
    chk("t1_n", got.size() >= 3, 1);
    if (got.size() >= 3) begin
      chk("t1_pc0", got[0].pc, 32'h0);
      chk("t1_pc1", got[1].pc, 32'h4);
      chk("t1_pc2", got[2].pc, 32'h8);
    end

    // Decode stalled: credit stops fetch at depth.
    step(1, 0, 0, 0, 0, 0);
    ngrant = 0;
    for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 0, 0);
    chk("t2_grants", ngrant, 2);
    chk("t2_req", imem_req, 0);
    got.delete();
    for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0, 0);
    chk("t2_n", got.size() >= 3, 1);
    if (got.size() >= 3) begin
      chk("t2_pc0", got[0].pc, 32'h0);
      chk("t2_pc1", got[1].pc, 32'h4);
      chk("t2_pc2", got[2].pc, 32'h8);
    end

    // Redirect while 0x8 is in flight.
    step(1, 0, 0, 0, 0, 0);
    ngrant = 0;
    for (int i = 0; i < 20 && ngrant < 3; i++)
      step(0, 1, 1, 0, 0, 3);
    chk("t3_g8", ngrant, 3);
    step(0, 0, 1, 1, 32'h100, 0);
    got.delete();
    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0);
    chk("t3_n", got.size() >= 2, 1);
    if (got.size() >= 2) begin
      chk("t3_pc0", got[0].pc, 32'h100);
      chk("t3_pc1", got[1].pc, 32'h104);
    end

    // Redirect coinciding with pop and response.
    for (int i = 0; i < 10; i++)
      step(0, 1, 1, 0, 32'h200, 0, 1'b1);
    got.delete();
    step(0, 1, 1, 1, 32'h200, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 0, 0);
    chk("t4_n", got.size() >= 1, 1);
    if (got.size() >= 1) chk("t4_pc0", got[0].pc, 32'h200);

    // No grant: address holds, FIFO drains.
    step(0, 0, 1, 1, 32'hC, 0);
    a0 = mpc;
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
    chk("t5_addr", imem_addr, a0);
    chk("t5_valid", instr_valid, 0);

    // Reset with FIFO full.
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 0);
    chk("t6_full", instr_valid, 1);
    step(1, 1, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("t6_addr", imem_addr, RPC);
    chk("t6_req", imem_req, 1);
    chk("t6_valid", instr_valid, 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 299) == 0,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0,
           $urandom,
           $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
